// File: rtl/operand_fetch_if.sv
// Purpose : decode-side and execute-side valid/ready bundle of the operand fetch stage.
// Ports   : in_*  decode -> stage (valid, rs1, rs2, rd, tag; ready back)
//           out_* stage -> execute (valid, op1, op2, rd, tag; ready back)
interface operand_fetch_if #(
  parameter int DATA_W = 36,
  parameter int ADDR_W = 5,
  parameter int TAG_W  = 36
);
  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] in_rs1;
  logic [ADDR_W-1:0] in_rs2;
  logic [ADDR_W-1:0] in_rd;
  logic [TAG_W-1:0]  in_tag;

  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_op1;
  logic [DATA_W-1:0] out_op2;
  logic [ADDR_W-1:0] out_rd;
  logic [TAG_W-1:0]  out_tag;

  // Stage side: consumes decode, produces for execute.
  modport slave (
    input  in_valid, in_rs1, in_rs2, in_rd, in_tag,
    output in_ready,
    output out_valid, out_op1, out_op2, out_rd, out_tag,
    input  out_ready
  );

  // Environment side: decode producer plus execute consumer.
  modport master (
    output in_valid, in_rs1, in_rs2, in_rd, in_tag,
    input  in_ready,
    input  out_valid, out_op1, out_op2, out_rd, out_tag,
    output out_ready
  );
endinterface

// File: rtl/operand_fetch.sv
// Purpose : operand fetch between decode and execute; drives register file reads, bypasses writeback.
// Latency : accept at edge E0 -> out_valid after E1; 1 instruction/cycle sustained.
// Backpressure: S1 + OUT act as a 2-entry pipe; in_ready drops combinationally when both are full and out_ready=0.
// Ports   : clk, rst (sync, active high), i_flush; io (operand_fetch_if.slave);
//           o_rf_read1/2_addr -> register file, i_rf_read1/2 <- register file (1-cycle registered);
//           i_wb_enable/i_wb_addr/i_wb_data = writeback port also writing the register file.
module operand_fetch #(
  parameter int DATA_W = 36,
  parameter int ADDR_W = 5,
  parameter int TAG_W  = 36
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_flush,
  operand_fetch_if.slave    io,
  output logic [ADDR_W-1:0] o_rf_read1_addr,
  output logic [ADDR_W-1:0] o_rf_read2_addr,
  input  logic [DATA_W-1:0] i_rf_read1,
  input  logic [DATA_W-1:0] i_rf_read2,
  input  logic              i_wb_enable,
  input  logic [ADDR_W-1:0] i_wb_addr,
  input  logic [DATA_W-1:0] i_wb_data
);

  // Stage S1: register file read in flight
  logic              r_s1_valid;
  logic [ADDR_W-1:0] r_s1_rs1, r_s1_rs2, r_s1_rd;
  logic [TAG_W-1:0]  r_s1_tag;
  logic              r_s1_byp1, r_s1_byp2;
  logic [DATA_W-1:0] r_s1_bypd1, r_s1_bypd2;

  // Stage OUT: final operands
  logic              r_out_valid;
  logic [DATA_W-1:0] r_out_op1, r_out_op2;
  logic [ADDR_W-1:0] r_out_rs1, r_out_rs2, r_out_rd;
  logic [TAG_W-1:0]  r_out_tag;

  logic              w_adv, w_in_ready, w_accept;
  logic [ADDR_W-1:0] w_rd_addr1, w_rd_addr2;
  logic              w_hit_rd1, w_hit_rd2, w_hit_s1_1, w_hit_s1_2, w_hit_out1, w_hit_out2;
  logic [DATA_W-1:0] w_eff1, w_eff2;

  assign w_adv      = r_s1_valid & (~r_out_valid | io.out_ready);
  assign w_in_ready = ~i_flush & (~r_s1_valid | w_adv);
  assign w_accept   = io.in_valid & w_in_ready;

  // A held S1 keeps presenting its own addresses, so the read is refreshed every cycle.
  assign w_rd_addr1      = w_accept ? io.in_rs1 : r_s1_rs1;
  assign w_rd_addr2      = w_accept ? io.in_rs2 : r_s1_rs2;
  assign o_rf_read1_addr = w_rd_addr1;
  assign o_rf_read2_addr = w_rd_addr2;

  // Writeback hits; register 0 is never bypassed.
  assign w_hit_rd1  = i_wb_enable & (i_wb_addr == w_rd_addr1) & (w_rd_addr1 != '0);
  assign w_hit_rd2  = i_wb_enable & (i_wb_addr == w_rd_addr2) & (w_rd_addr2 != '0);
  assign w_hit_s1_1 = i_wb_enable & (i_wb_addr == r_s1_rs1) & (r_s1_rs1 != '0);
  assign w_hit_s1_2 = i_wb_enable & (i_wb_addr == r_s1_rs2) & (r_s1_rs2 != '0);
  assign w_hit_out1 = i_wb_enable & (i_wb_addr == r_out_rs1) & (r_out_rs1 != '0);
  assign w_hit_out2 = i_wb_enable & (i_wb_addr == r_out_rs2) & (r_out_rs2 != '0);

  // The register file returns pre-write data when read and written on the same edge;
  // the captured bypass flag/data replaces that stale value.
  assign w_eff1 = (r_s1_rs1 == '0) ? '0 : (r_s1_byp1 ? r_s1_bypd1 : i_rf_read1);
  assign w_eff2 = (r_s1_rs2 == '0) ? '0 : (r_s1_byp2 ? r_s1_bypd2 : i_rf_read2);

  assign io.in_ready  = w_in_ready;
  assign io.out_valid = r_out_valid;
  assign io.out_op1   = r_out_op1;
  assign io.out_op2   = r_out_op2;
  assign io.out_rd    = r_out_rd;
  assign io.out_tag   = r_out_tag;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid  <= 1'b0;
      r_s1_rs1    <= '0;
      r_s1_rs2    <= '0;
      r_s1_rd     <= '0;
      r_s1_tag    <= '0;
      r_s1_byp1   <= 1'b0;
      r_s1_byp2   <= 1'b0;
      r_s1_bypd1  <= '0;
      r_s1_bypd2  <= '0;
      r_out_valid <= 1'b0;
      r_out_op1   <= '0;
      r_out_op2   <= '0;
      r_out_rs1   <= '0;
      r_out_rs2   <= '0;
      r_out_rd    <= '0;
      r_out_tag   <= '0;
    end else begin
      r_s1_byp1  <= w_hit_rd1;
      r_s1_byp2  <= w_hit_rd2;
      r_s1_bypd1 <= i_wb_data;
      r_s1_bypd2 <= i_wb_data;

      if (w_accept) begin
        r_s1_valid <= 1'b1;
        r_s1_rs1   <= io.in_rs1;
        r_s1_rs2   <= io.in_rs2;
        r_s1_rd    <= io.in_rd;
        r_s1_tag   <= io.in_tag;
      end else if (w_adv) begin
        r_s1_valid <= 1'b0;
      end

      if (w_adv) begin
        r_out_valid <= 1'b1;
        r_out_op1   <= w_hit_s1_1 ? i_wb_data : w_eff1;
        r_out_op2   <= w_hit_s1_2 ? i_wb_data : w_eff2;
        r_out_rs1   <= r_s1_rs1;
        r_out_rs2   <= r_s1_rs2;
        r_out_rd    <= r_s1_rd;
        r_out_tag   <= r_s1_tag;
      end else if (io.out_ready) begin
        r_out_valid <= 1'b0;
      end else if (r_out_valid) begin
        // Stalled operands keep tracking writeback so execute never sees stale data.
        if (w_hit_out1) r_out_op1 <= i_wb_data;
        if (w_hit_out2) r_out_op2 <= i_wb_data;
      end

      if (i_flush) begin
        r_s1_valid  <= 1'b0;
        r_out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_operand_fetch.sv
module tb_operand_fetch;
  localparam int DW = 36;
  localparam int AW = 5;
  localparam int TW = 36;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic [AW-1:0] rf_a1, rf_a2;
  logic [DW-1:0] rf_d1, rf_d2;
  logic          wb_en;
  logic [AW-1:0] wb_addr;
  logic [DW-1:0] wb_data;
  int            n_err = 0;
  int            n_chk = 0;

  always #5 clk = ~clk;

  operand_fetch_if #(.DATA_W(DW), .ADDR_W(AW), .TAG_W(TW)) u_if ();

  operand_fetch #(.DATA_W(DW), .ADDR_W(AW), .TAG_W(TW)) u_dut (
    .clk             (clk),
    .rst             (rst),
    .i_flush         (flush),
    .io              (u_if),
    .o_rf_read1_addr (rf_a1),
    .o_rf_read2_addr (rf_a2),
    .i_rf_read1      (rf_d1),
    .i_rf_read2      (rf_d2),
    .i_wb_enable     (wb_en),
    .i_wb_addr       (wb_addr),
    .i_wb_data       (wb_data)
  );

  // Register file: registered read, read-during-write returns the old contents,
  // and register 0 is physically writable (the stage must mask it).
  logic [DW-1:0] rf_mem [32];
  always @(posedge clk) begin
    if (wb_en) rf_mem[wb_addr] <= wb_data;
    rf_d1 <= rf_mem[rf_a1];
    rf_d2 <= rf_mem[rf_a2];
  end

  // Reference: architectural register values plus the in-order list of accepted
  // instructions. An entry is visible to execute once an edge has passed since its accept.
  typedef struct {
    logic [AW-1:0] rs1;
    logic [AW-1:0] rs2;
    logic [AW-1:0] rd;
    logic [TW-1:0] tag;
    bit            fresh;
  } ent_t;
  ent_t          q[$];
  logic [DW-1:0] arch [32];

  function automatic logic [DW-1:0] arch_val(input logic [AW-1:0] a);
    return (a == '0) ? '0 : arch[a];
  endfunction

  function automatic logic [DW-1:0] rnd36();
    logic [63:0] t;
    t = {$urandom, $urandom};
    return t[DW-1:0];
  endfunction

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp_v);
    n_chk++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", name, obs, exp_v);
    end
  endtask

  task automatic set_idle();
    u_if.in_valid  = 1'b0;
    u_if.out_ready = 1'b1;
    flush          = 1'b0;
    wb_en          = 1'b0;
  endtask

  task automatic offer(input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                       input logic [AW-1:0] rd, input logic [TW-1:0] tag);
    u_if.in_valid = 1'b1;
    u_if.in_rs1   = rs1;
    u_if.in_rs2   = rs2;
    u_if.in_rd    = rd;
    u_if.in_tag   = tag;
  endtask

  task automatic wb(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wb_en   = 1'b1;
    wb_addr = a;
    wb_data = d;
  endtask

  // Check the cycle's outputs against the reference, advance the reference over the edge, clock once.
  task automatic tick();
    bit   exp_ov, s1_occ, exp_ir;
    ent_t e;
    #1;
    exp_ov = (q.size() > 0) && !q[0].fresh;
    s1_occ = (q.size() == 2) || (q.size() == 1 && q[0].fresh);
    exp_ir = !flush && (!s1_occ || !exp_ov || u_if.out_ready);
    if (!rst) begin
      chk("in_ready", u_if.in_ready, exp_ir);
      chk("out_valid", u_if.out_valid, exp_ov);
      if (exp_ov) begin
        chk("out_op1", u_if.out_op1, arch_val(q[0].rs1));
        chk("out_op2", u_if.out_op2, arch_val(q[0].rs2));
        chk("out_rd", u_if.out_rd, q[0].rd);
        chk("out_tag", u_if.out_tag, q[0].tag);
      end
    end
    if (rst) begin
      q.delete();
    end else begin
      if (exp_ov && u_if.out_ready) void'(q.pop_front());
      foreach (q[i]) q[i].fresh = 1'b0;
      if (u_if.in_valid && exp_ir) begin
        e.rs1   = u_if.in_rs1;
        e.rs2   = u_if.in_rs2;
        e.rd    = u_if.in_rd;
        e.tag   = u_if.in_tag;
        e.fresh = 1'b1;
        q.push_back(e);
      end
      if (flush) q.delete();
    end
    if (wb_en) arch[wb_addr] = wb_data;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string pfx);
    chk({pfx, "_out_valid"}, u_if.out_valid, 1'b0);
    chk({pfx, "_out_op1"}, u_if.out_op1, '0);
    chk({pfx, "_out_op2"}, u_if.out_op2, '0);
    chk({pfx, "_out_rd"}, u_if.out_rd, '0);
    chk({pfx, "_out_tag"}, u_if.out_tag, '0);
    chk({pfx, "_in_ready"}, u_if.in_ready, 1'b1);
  endtask

  initial begin
    int cnt, first, last;
    rst = 1'b1;
    set_idle();
    offer('0, '0, '0, '0);
    u_if.in_valid = 1'b0;
    wb_addr = '0;
    wb_data = '0;

    // Reset while loading every register (including r0) with random data.
    for (int i = 0; i < 32; i++) begin
      wb(AW'(i), rnd36());
      tick();
    end
    wb_en = 1'b0;
    tick();
    rst = 1'b0;
    chk_reset_outputs("reset");

    // Write r5 at an idle edge, accept rs1=5/rs2=0 two cycles later.
    wb(5'd5, 36'h123456789);
    tick();
    wb_en = 1'b0;
    tick();
    offer(5'd5, 5'd0, 5'd9, 36'h1);
    tick();
    u_if.in_valid = 1'b0;
    tick();
    chk("t1_valid", u_if.out_valid, 1'b1);
    chk("t1_op1", u_if.out_op1, 36'h123456789);
    chk("t1_op2", u_if.out_op2, '0);

    // Accept rs1=7 on the edge that writes r7.
    offer(5'd7, 5'd0, 5'd1, 36'h2);
    wb(5'd7, 36'hA5A5A5A5A);
    tick();
    u_if.in_valid = 1'b0;
    wb_en = 1'b0;
    tick();
    chk("t2a_op1", u_if.out_op1, 36'hA5A5A5A5A);
    // Same, with the write on the following edge (while in S1).
    offer(5'd7, 5'd0, 5'd1, 36'h3);
    tick();
    u_if.in_valid = 1'b0;
    wb(5'd7, 36'h5A5A5A5A5);
    tick();
    wb_en = 1'b0;
    chk("t2b_op1", u_if.out_op1, 36'h5A5A5A5A5);
    tick();

    // Stall with both stages full; two writes to r3, last wins.
    u_if.out_ready = 1'b0;
    offer(5'd3, 5'd1, 5'd4, 36'h30);
    tick();
    offer(5'd2, 5'd3, 5'd5, 36'h31);
    tick();
    offer(5'd3, 5'd3, 5'd6, 36'h32);
    wb(5'd3, 36'h1);
    tick();
    wb(5'd3, 36'h2);
    tick();
    wb_en = 1'b0;
    chk("stall_op1", u_if.out_op1, 36'h2);
    chk("stall_in_ready", u_if.in_ready, 1'b0);
    u_if.in_valid = 1'b0;
    u_if.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) tick();

    // Eight back-to-back instructions, execute always ready.
    cnt = 0; first = -1; last = -1;
    for (int i = 0; i < 10; i++) begin
      if (i < 8) offer(AW'($urandom_range(0, 31)), AW'($urandom_range(0, 31)), AW'(i), TW'(i));
      else u_if.in_valid = 1'b0;
      tick();
      if (u_if.out_valid) begin
        cnt++;
        if (first < 0) first = i;
        last = i;
      end
    end
    chk("b2b_count", cnt, 8);
    chk("b2b_span", last - first, 7);

    // Writes to r0 must never reach an operand.
    offer(5'd0, 5'd5, 5'd2, 36'h40);
    wb(5'd0, 36'hFFFFFFFFF);
    tick();
    u_if.in_valid = 1'b0;
    u_if.out_ready = 1'b0;
    tick();
    chk("r0_op1", u_if.out_op1, '0);
    tick();
    chk("r0_op1_stalled", u_if.out_op1, '0);
    wb_en = 1'b0;
    u_if.out_ready = 1'b1;
    tick();

    // Flush with both stages full and decode offering.
    u_if.out_ready = 1'b0;
    offer(5'd1, 5'd2, 5'd3, 36'h50);
    tick();
    offer(5'd2, 5'd1, 5'd3, 36'h51);
    tick();
    offer(5'd4, 5'd4, 5'd3, 36'h77);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    u_if.in_valid = 1'b0;
    u_if.out_ready = 1'b1;
    chk("flush_out_valid", u_if.out_valid, 1'b0);
    tick();
    chk("flush_s1_empty", u_if.out_valid, 1'b0);

    // Reset in the middle of a stall.
    u_if.out_ready = 1'b0;
    offer(5'd5, 5'd7, 5'd8, 36'h60);
    tick();
    offer(5'd7, 5'd5, 5'd9, 36'h61);
    tick();
    u_if.in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_reset_outputs("midrst");

    // Random traffic with hot registers for frequent bypass.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 9) < 7)
        offer(AW'($urandom_range(0, 3)), AW'($urandom_range(0, 3)), AW'($urandom_range(0, 31)), TW'($urandom));
      else
        u_if.in_valid = 1'b0;
      if ($urandom_range(0, 1) == 1) wb(AW'($urandom_range(0, 3)), rnd36());
      else wb_en = 1'b0;
      u_if.out_ready = ($urandom_range(0, 9) < 6);
      flush = ($urandom_range(0, 29) == 0);
      tick();
    end

    set_idle();
    for (int i = 0; i < 4; i++) tick();
    chk("drain_empty", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/operand_fetch.md
Name: operand_fetch

Overview:
- Pipeline stage between decode and execute; the only consumer of the 36-bit, 32-entry register file's read ports.
- Drives the register file's read addresses and absorbs its one-cycle registered read latency.
- Bypasses writeback data that the register file would return stale.
- Presents operand pairs to execute over a valid/ready handshake, with full stall support.

Parameters:
- DATA_W, 36, operand/register width; must match the register file.
- ADDR_W, 5, register address width (32 registers).
- TAG_W, 36, width of the opaque payload (instruction word) carried alongside the operands.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- flush  in  1  synchronous pipeline kill; both stages go empty
- in_valid  in  1  decode offers an instruction
- in_ready  out  1  stage accepts this cycle
- in_rs1  in  ADDR_W  source register 1
- in_rs2  in  ADDR_W  source register 2
- in_rd  in  ADDR_W  destination, passed through
- in_tag  in  TAG_W  payload, passed through
- rf_read1_addr  out  ADDR_W  to register file read1_addr
- rf_read2_addr  out  ADDR_W  to register file read2_addr
- rf_read1  in  DATA_W  register file read1 (registered; valid the cycle after its address is presented)
- rf_read2  in  DATA_W  register file read2
- wb_enable  in  1  writeback write strobe, the same signal driving the register file write_enable
- wb_addr  in  ADDR_W  writeback address
- wb_data  in  DATA_W  writeback data
- out_valid  out  1  operands valid to execute
- out_ready  in  1  execute accepts
- out_op1  out  DATA_W  operand 1
- out_op2  out  DATA_W  operand 2
- out_rd  out  ADDR_W  destination
- out_tag  out  TAG_W  payload

Behaviour:
- Reset (rst=1 at an edge): s1_valid=0, out_valid=0, out_op1/out_op2/out_rd/out_tag=0, bypass flags=0. in_ready reads 1 after reset. rst overrides flush and all handshakes.
- Pipeline structure:
  - Stage S1 holds rs1, rs2, rd and tag while the register file read is in flight.
  - Stage OUT holds the final operands.
- Control terms:
  - adv = s1_valid & (!out_valid | out_ready)
  - in_ready = !flush & (!s1_valid | adv)
  - accept = in_valid & in_ready
- Read address mux (combinational): rf_readN_addr = accept ? in_rsN : s1_rsN. A held S1 therefore re-reads its registers every cycle.
- Write hit: hitN(a) = wb_enable & (wb_addr == a) & (a != 0).
- Bypass tracking, every edge, per operand N:
  - s1_bypN <= hitN(rf_readN_addr)
  - s1_bypdN <= wb_data
  - This covers the register file's read-during-write returning old data.
- Effective S1 operand: effN = (s1_rsN == 0) ? 0 : s1_bypN ? s1_bypdN : rf_readN.
- S1 update:
  - On accept, load S1 from in_* and set s1_valid=1.
  - Else on adv, clear s1_valid.
  - Else hold.
- OUT update:
  - On adv: out_opN <= hitN(s1_rsN) ? wb_data : effN. Load rd and tag; set out_valid=1.
  - Else on out_ready, clear out_valid.
  - Else if out_valid (stalled): out_opN <= hitN(out_rsN) ? wb_data : out_opN. The stage keeps out_rs1/out_rs2 internally for this.
- Register 0 always yields 0 and is never bypassed, including a write to address 0.
- Latency and throughput:
  - Accept at edge E0 gives out_valid high after E1.
  - Sustained throughput is 1 instruction/cycle with out_ready held high.
  - A full pipeline with out_ready=0 drops in_ready the same cycle. No data is lost or duplicated.
- Simultaneous events:
  - Accept and adv on the same edge is legal: S1 reloads and OUT takes the old S1.
  - Multiple writes to the same register while stalled: the last write wins.
- flush=1 at an edge: s1_valid=0 and out_valid=0. in_ready=0 that cycle, so nothing is accepted. Data registers may hold stale values.

Test Plan:
- Reset, then write r5=0x123456789 at an idle edge. Accept rs1=5, rs2=0 two cycles later -> after 2 edges out_valid=1, op1=0x123456789, op2=0.
- Accept rs1=7 on the same edge that wb writes r7=0xA5A5A5A5A -> op1=0xA5A5A5A5A (stale register file value rejected). Repeat with the write at edge E1 -> same result.
- out_ready=0, pipeline full with rs1=3 in OUT. wb writes r3=0x1 then r3=0x2 -> op1=0x2; in_ready=0 until out_ready=1; no instruction dropped.
- Back-to-back 8 instructions with tags 0..7, out_ready=1 continuously -> 8 consecutive out_valid cycles, tags in order, throughput 1/cycle.
- wb writes r0=0xFFFFFFFFF while an instruction with rs1=0 is in flight -> op1=0.
- flush while both stages are valid, with in_valid=1 -> next cycle out_valid=0, s1 empty, the offered instruction is not accepted. rst mid-stall -> all outputs 0.
